// File: rtl/audio_i2s_receiver.sv
// audio_i2s_receiver: oversampled I2S receiver, MSB first, 1-BCK delay slot.
// Define I2S_RX_FRAME_ERR_EN for o_frame_err pulses and the err_cnt_q counter.
module audio_i2s_receiver #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    reset1,
   input  logic                    iAUD_BCK,
   input  logic                    iAUD_LRCK,
   input  logic                    iAUD_DATA,
   output logic signed [WIDTH-1:0] o_lsound_in,
   output logic signed [WIDTH-1:0] o_rsound_in,
   output logic                    o_valid,
   output logic                    o_frame_err
);

   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] IDLE = CW'(WIDTH + 1);

   logic [SYNC_STAGES-1:0] bck_sync_q, bck_sync_d;
   logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;

   logic             bck_d_q, bck_d_d;
   logic             lr_prev_q, lr_prev_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             chan_q, chan_d;
   logic             armed_q, armed_d;
   logic             left_ok_q, left_ok_d;
   logic [WIDTH-2:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] lbuf_q, lbuf_d;
   logic [WIDTH-1:0] lsound_q, lsound_d;
   logic [WIDTH-1:0] rsound_q, rsound_d;
   logic             valid_q, valid_d;

   logic             bck_s, lrck_s, data_s;
   logic             bck_rise, lr_chg;
   logic             cnt_open, lsb_now, cap;
   logic [WIDTH-1:0] word;

   assign bck_s    = bck_sync_q[SYNC_STAGES-1];
   assign lrck_s   = lrck_sync_q[SYNC_STAGES-1];
   assign data_s   = data_sync_q[SYNC_STAGES-1];
   assign bck_rise = bck_s & ~bck_d_q;
   assign lr_chg   = lrck_s ^ lr_prev_q;
   assign word     = {shreg_q, data_s};
   assign cnt_open = armed_q & (bit_cnt_q < LAST);
   // LSB lands either inside the slot or on the next slot's delay edge
   assign lsb_now  = armed_q & (bit_cnt_q == LAST);
   assign cap      = bck_rise & lsb_now;

   always_comb begin
      bck_sync_d  = {bck_sync_q[SYNC_STAGES-2:0], iAUD_BCK};
      lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], iAUD_LRCK};
      data_sync_d = {data_sync_q[SYNC_STAGES-2:0], iAUD_DATA};
      bck_d_d     = bck_s;
   end

   always_comb begin
      lr_prev_d = lr_prev_q;
      bit_cnt_d = bit_cnt_q;
      chan_d    = chan_q;
      armed_d   = armed_q;
      shreg_d   = shreg_q;
      lbuf_d    = lbuf_q;
      left_ok_d = left_ok_q;
      lsound_d  = lsound_q;
      rsound_d  = rsound_q;
      valid_d   = 1'b0;
      if (bck_rise) begin
         lr_prev_d = lrck_s;
         if (lr_chg) begin
            bit_cnt_d = '0;
            chan_d    = lrck_s;
            armed_d   = 1'b1;
         end else if (cnt_open) begin
            shreg_d   = word[WIDTH-2:0];
            bit_cnt_d = bit_cnt_q + CW'(1);
         end else if (lsb_now) begin
            bit_cnt_d = IDLE;
         end
      end
      if (bck_rise && lr_chg && cnt_open && !chan_q) begin
         left_ok_d = 1'b0;
      end
      if (cap) begin
         if (!chan_q) begin
            lbuf_d    = word;
            left_ok_d = 1'b1;
         end else if (left_ok_q) begin
            lsound_d  = lbuf_q;
            rsound_d  = word;
            valid_d   = 1'b1;
            left_ok_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset1) begin
      if (reset1) begin
         bck_sync_q  <= '0;
         lrck_sync_q <= '0;
         data_sync_q <= '0;
         bck_d_q     <= 1'b0;
         lr_prev_q   <= 1'b0;
         bit_cnt_q   <= IDLE;
         chan_q      <= 1'b0;
         armed_q     <= 1'b0;
         left_ok_q   <= 1'b0;
         shreg_q     <= '0;
         lbuf_q      <= '0;
         lsound_q    <= '0;
         rsound_q    <= '0;
         valid_q     <= 1'b0;
      end else begin
         bck_sync_q  <= bck_sync_d;
         lrck_sync_q <= lrck_sync_d;
         data_sync_q <= data_sync_d;
         bck_d_q     <= bck_d_d;
         lr_prev_q   <= lr_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         chan_q      <= chan_d;
         armed_q     <= armed_d;
         left_ok_q   <= left_ok_d;
         shreg_q     <= shreg_d;
         lbuf_q      <= lbuf_d;
         lsound_q    <= lsound_d;
         rsound_q    <= rsound_d;
         valid_q     <= valid_d;
      end
   end

   assign o_lsound_in = lsound_q;
   assign o_rsound_in = rsound_q;
   assign o_valid     = valid_q;

`ifdef I2S_RX_FRAME_ERR_EN
   logic        short_slot, orphan, fault;
   logic        err_q, err_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   assign short_slot = bck_rise & lr_chg & cnt_open;
   assign orphan     = cap & chan_q & ~left_ok_q;
   assign fault      = short_slot | orphan;

   always_comb begin
      err_d     = fault;
      err_cnt_d = err_cnt_q;
      if (fault && err_cnt_q != 16'hFFFF) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset1) begin
      if (reset1) begin
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign o_frame_err = err_q;
`else
   assign o_frame_err = 1'b0;
`endif

endmodule
